// File: rtl/inv_data_registers_unit.sv
// Byte-serial AES-128 decrypt state: load, InvMixColumns, InvShiftRows, unload.
// Optional macro STATE_CLEAR_EN zeroizes the state on the done cycle.
module inv_data_registers_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       skip_mc,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    IMC,
    ISR,
    UNLOAD
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] s [16];
  logic [3:0] k;
  logic       skip_q;
  logic       in_fire;
  logic       out_fire;
  logic       last;
  logic [7:0] m0, m1, m2, m3;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  assign m0 = mule(s[0]) ^ mulb(s[1]) ^ muld(s[2]) ^ mul9(s[3]);
  assign m1 = mul9(s[0]) ^ mule(s[1]) ^ mulb(s[2]) ^ muld(s[3]);
  assign m2 = muld(s[0]) ^ mul9(s[1]) ^ mule(s[2]) ^ mulb(s[3]);
  assign m3 = mulb(s[0]) ^ muld(s[1]) ^ mul9(s[2]) ^ mule(s[3]);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last     = (k == 4'd15);
  assign out_data = s[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_fire && last)
          state_nxt = skip_q ? ISR : IMC;
      end
      IMC: begin
        if (last) state_nxt = ISR;
      end
      ISR: begin
        state_nxt = UNLOAD;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_fire && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) s[i] <= 8'h00;
      k      <= 4'd0;
      skip_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          k <= 4'd0;
          if (start) skip_q <= skip_mc;
        end
        LOAD: begin
          if (in_fire) begin
            for (int i = 0; i < 15; i++) s[i] <= s[i+1];
            s[15] <= in_data;
            k     <= k + 4'd1;
          end
        end
        IMC: begin
          // Rotate every cycle; on a column boundary the mixed column
          // is written back so it lands in place after 16 rotations.
          for (int i = 0; i < 15; i++) s[i] <= s[i+1];
          s[15] <= s[0];
          if (k[1:0] == 2'd0) begin
            s[15] <= m0;
            s[0]  <= m1;
            s[1]  <= m2;
            s[2]  <= m3;
          end
          k <= k + 4'd1;
        end
        ISR: begin
          s[1]  <= s[13];
          s[5]  <= s[1];
          s[9]  <= s[5];
          s[13] <= s[9];
          s[2]  <= s[10];
          s[6]  <= s[14];
          s[10] <= s[2];
          s[14] <= s[6];
          s[3]  <= s[7];
          s[7]  <= s[11];
          s[11] <= s[15];
          s[15] <= s[3];
          k     <= 4'd0;
        end
        UNLOAD: begin
          if (out_ready) begin
            for (int i = 0; i < 15; i++) s[i] <= s[i+1];
            s[15] <= s[0];
            k     <= k + 4'd1;
            if (last) begin
              done <= 1'b1;
`ifdef STATE_CLEAR_EN
              for (int i = 0; i < 16; i++) s[i] <= 8'h00;
`else
`endif
            end
          end
        end
        default: k <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_data_registers_unit.sv
// Bench for inv_data_registers_unit: directed and randomized rounds
// compared against a GF(2^8) reference model of InvMixColumns/InvShiftRows.
module tb_inv_data_registers_unit;

  typedef logic [7:0] blk_t [16];

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       skip_mc;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  inv_data_registers_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .skip_mc   (skip_mc),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return gm_ret(p);
  endfunction

  function automatic logic [7:0] gm_ret(input logic [7:0] p);
    return p;
  endfunction

  task automatic inv_mix(input blk_t din, output blk_t dout);
    logic [7:0] coef [4];
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        dout[4*c+r] = 8'h00;
        for (int j = 0; j < 4; j++)
          dout[4*c+r] ^= gm(coef[(j - r + 4) % 4], din[4*c+j]);
      end
  endtask

  task automatic inv_shift(input blk_t din, output blk_t dout);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        dout[4*c+r] = din[4*((c - r + 4) % 4) + r];
  endtask

  task automatic model(input blk_t din, input bit skip, output blk_t dout);
    blk_t t;
    if (skip) t = din;
    else inv_mix(din, t);
    inv_shift(t, dout);
  endtask

  task automatic run_round(input blk_t din, input bit skip, input bit stall,
                           input bit extra_start, output blk_t dout,
                           output int lat, output int dones);
    int  ip = 0;
    int  op = 0;
    int  cyc = 0;
    bit  exp_done = 1'b0;
    bit  fin = 1'b0;
    lat   = -1;
    dones = 0;
    for (int i = 0; i < 16; i++) dout[i] = 8'hxx;
    @(negedge clk);
    start     = 1'b1;
    skip_mc   = skip;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start   = extra_start && (cyc == 20);
      skip_mc = ~skip;
      if (done) dones++;
      chk("done_pulse", {31'd0, done}, {31'd0, exp_done});
      exp_done = 1'b0;
      if (fin) break;
      if (out_valid && lat < 0) lat = cyc;
      in_data  = (ip < 16) ? din[ip] : 8'h00;
      in_valid = (ip < 16) && (!stall || $urandom_range(0, 3) != 0);
      if (in_valid && in_ready) ip++;
      out_ready = !stall || ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        dout[op] = out_data;
        op++;
        if (op == 16) begin
          exp_done = 1'b1;
          fin      = 1'b1;
        end
      end
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!fin) chk("round_timeout", 32'd0, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic cmp_blk(input string tag, input blk_t got, input blk_t exp);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s[%0d]", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
  endtask

  task automatic chk_idle(input blk_t res);
`ifdef STATE_CLEAR_EN
    chk("idle_s0_cleared", {24'd0, out_data}, 32'd0);
`else
    chk("idle_s0_held", {24'd0, out_data}, {24'd0, res[0]});
`endif
  endtask

  initial begin
    blk_t din, dout, exp, tmp, ref_out;
    int   lat, dones;

    rst = 1'b1; start = 1'b0; skip_mc = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Abort a round after five bytes with an asynchronous reset.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 8'h40);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midload_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) din[i] = 8'($urandom_range(0, 255));
    run_round(din, 1'b0, 1'b0, 1'b0, dout, lat, dones);
    model(din, 1'b0, exp);
    cmp_blk("after_abort", dout, exp);

    din = '{8'hdb, 8'h13, 8'h53, 8'h45, 8'hdb, 8'h13, 8'h53, 8'h45,
            8'hdb, 8'h13, 8'h53, 8'h45, 8'hdb, 8'h13, 8'h53, 8'h45};
    run_round(din, 1'b0, 1'b0, 1'b0, dout, lat, dones);
    model(din, 1'b0, exp);
    cmp_blk("db135345", dout, exp);
    chk("lat_imc", lat, 32'd34);
    chk("done_once", dones, 32'd1);
    chk_idle(exp);

    din = '{8'hf2, 8'h0a, 8'h22, 8'h5c, 8'h01, 8'h01, 8'h01, 8'h01,
            8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'hd4, 8'hd4, 8'hd4, 8'hd5};
    run_round(din, 1'b0, 1'b0, 1'b0, dout, lat, dones);
    model(din, 1'b0, exp);
    cmp_blk("mixed_cols", dout, exp);

    // Known MixColumns outputs; the inverse restores the FIPS-197 columns.
    din = '{8'h8e, 8'h4d, 8'ha1, 8'hbc, 8'h9f, 8'hdc, 8'h58, 8'h9d,
            8'h01, 8'h01, 8'h01, 8'h01, 8'hd5, 8'hd5, 8'hd7, 8'hd6};
    tmp = '{8'hdb, 8'h13, 8'h53, 8'h45, 8'hf2, 8'h0a, 8'h22, 8'h5c,
            8'h01, 8'h01, 8'h01, 8'h01, 8'hd4, 8'hd4, 8'hd4, 8'hd5};
    inv_shift(tmp, exp);
    run_round(din, 1'b0, 1'b0, 1'b0, dout, lat, dones);
    cmp_blk("known_cols", dout, exp);

    for (int i = 0; i < 16; i++) din[i] = 8'(i);
    exp = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
            8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
    run_round(din, 1'b1, 1'b0, 1'b0, dout, lat, dones);
    cmp_blk("skip_mc", dout, exp);
    chk("lat_skip", lat, 32'd18);
    chk_idle(exp);

    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 16; i++) din[i] = 8'($urandom_range(0, 255));
      model(din, n[0], exp);
      run_round(din, n[0], 1'b0, 1'b0, ref_out, lat, dones);
      cmp_blk("rand_nostall", ref_out, exp);
      run_round(din, n[0], 1'b1, 1'b1, dout, lat, dones);
      cmp_blk("rand_stall", dout, ref_out);
      chk("stall_done_once", dones, 32'd1);
      chk_idle(exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
